sd_req_arbiter: RTL and testbench

Parametrised multi-device SD block-request sequencer sitting between the emulated disk controllers (floppy track loaders, ProDOS HDD) and the hps_io `sd_rd`/`sd_wr`/`sd_ack` per-device handshake. Latches single-cycle read/write pulses per device and grants one device at a time, round-robin or fixed priority. Runs the rd/wr → ack-rise → ack-fall sequence, holds `cpu_wait` while any work is outstanding, and adds unmounted-image rejection and an ack timeout.

---
 rtl/sd_arb_pkg.sv | 22 ++
 rtl/sd_req_arbiter_rr_pick.sv | 35 +++
 rtl/sd_req_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_sd_req_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types for the SD block-request sequencer.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER
    } st_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

    // Width of a device index; a single-device build still carries one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sd_req_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after the pointer (RR) or from index 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
// Ports: req_i request vector, ptr_i search start, rr_i rotate enable,
//        idx_o winning index, vld_o any request present.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          rr_i,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    always_comb begin
        int            j;
        logic [IW-1:0] jw;
        idx_o = '0;
        vld_o = 1'b0;
        j     = 0;
        jw    = '0;
        for (int i = 0; i < N; i++) begin
            j = (rr_i ? int'(ptr_i) : 0) + i;
            if (j >= N) j = j - N;
            jw = IW'(j);
            if (!vld_o && req_i[jw]) begin
                vld_o = 1'b1;
                idx_o = jw;
            end
        end
    end

endmodule

// File: rtl/sd_req_arbiter.sv
// Latches per-device SD read/write pulses and runs one rd/wr -> ack-rise -> ack-fall sequence at a time.
// Latency: pulse at t -> sd_rd/sd_wr at t+2; ack fall at f -> done at f+1, cpu_wait low at f+2.
// Backpressure: requests queue as pending flags (one rd + one wr per device); cpu_wait holds the CPU meanwhile.
// Ports: clk_sys/reset_n/soft_reset; req_rd/req_wr/req_lba per-device pulses; mounted image-present;
//        sd_ack from hps_io; sd_rd/sd_wr/sd_lba to hps_io; cpu_wait, busy, done, err status.
module sd_req_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NUM_DEV = 3,
    parameter int LBA_W   = 32,
    parameter int TMO_W   = 24,
    parameter int RR      = 1
) (
    input  logic                            clk_sys,
    input  logic                            reset_n,
    input  logic                            soft_reset,
    input  logic [NUM_DEV-1:0]              req_rd,
    input  logic [NUM_DEV-1:0]              req_wr,
    input  logic [NUM_DEV-1:0][LBA_W-1:0]   req_lba,
    input  logic [NUM_DEV-1:0]              mounted,
    input  logic [NUM_DEV-1:0]              sd_ack,
    output logic [NUM_DEV-1:0]              sd_rd,
    output logic [NUM_DEV-1:0]              sd_wr,
    output logic [NUM_DEV-1:0][LBA_W-1:0]   sd_lba,
    output logic                            cpu_wait,
    output logic [NUM_DEV-1:0]              busy,
    output logic [NUM_DEV-1:0]              done,
    output logic [NUM_DEV-1:0]              err
);

    localparam int IW = idx_width(NUM_DEV);

    st_t                          st_q;
    op_t                          op_q;
    logic [IW-1:0]                g_q, rr_ptr_q;
    logic [TMO_W-1:0]             tmo_q, tmo_d;
    logic [NUM_DEV-1:0]           pend_rd_q, pend_wr_q, pend_rd_d, pend_wr_d;
    logic [NUM_DEV-1:0]           clr_rd, clr_wr, ack_q;
    logic [NUM_DEV-1:0][LBA_W-1:0] lba_q, lba_d, sd_lba_q;
    logic [NUM_DEV-1:0]           sd_rd_q, sd_wr_q, done_q, err_q;
    logic                         cpu_wait_q;
    logic [IW-1:0]                pick_idx;
    logic                         pick_vld;
    logic                         ack_rise, ack_fall, tmo_hit;

    rr_pick #(.N(NUM_DEV), .IW(IW)) u_pick (
        .req_i (pend_rd_q | pend_wr_q),
        .ptr_i (rr_ptr_q),
        .rr_i  (RR != 0),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    assign ack_rise = sd_ack[g_q] & ~ack_q[g_q];
    assign ack_fall = ~sd_ack[g_q] & ack_q[g_q];
    assign tmo_d    = tmo_q + TMO_W'(1);
    // Fires in the REQ cycle whose increment lands on all-ones.
    assign tmo_hit  = &tmo_d;

    // Flags retired this cycle: rejected pick in IDLE, or the serviced op leaving REQ.
    always_comb begin
        clr_rd = '0;
        clr_wr = '0;
        case (st_q)
            IDLE: if (pick_vld && !mounted[pick_idx]) begin
                clr_rd[pick_idx] = 1'b1;
                clr_wr[pick_idx] = 1'b1;
            end
            REQ: if (ack_rise || tmo_hit) begin
                if (op_q == OP_WR) clr_wr[g_q] = 1'b1;
                else               clr_rd[g_q] = 1'b1;
            end
            default: ;
        endcase
    end

    // A new pulse in the same cycle as a clear keeps the flag set.
    assign pend_rd_d = (pend_rd_q & ~clr_rd) | req_rd;
    assign pend_wr_d = (pend_wr_q & ~clr_wr) | req_wr;

    always_comb begin
        lba_d = lba_q;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (req_rd[i] || req_wr[i]) lba_d[i] = req_lba[i];
        end
    end

    always_comb begin
        busy = pend_rd_q | pend_wr_q;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (st_q != IDLE && g_q == IW'(i)) busy[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            st_q       <= IDLE;
            op_q       <= OP_RD;
            g_q        <= '0;
            rr_ptr_q   <= '0;
            tmo_q      <= '0;
            pend_rd_q  <= '0;
            pend_wr_q  <= '0;
            lba_q      <= '0;
            ack_q      <= '0;
            sd_lba_q   <= '0;
            sd_rd_q    <= '0;
            sd_wr_q    <= '0;
            done_q     <= '0;
            err_q      <= '0;
            cpu_wait_q <= 1'b0;
        end else begin
            pend_rd_q  <= pend_rd_d;
            pend_wr_q  <= pend_wr_d;
            lba_q      <= lba_d;
            ack_q      <= sd_ack;
            done_q     <= '0;
            err_q      <= '0;
            cpu_wait_q <= (|(pend_rd_q | pend_wr_q)) | (st_q != IDLE);
            case (st_q)
                IDLE: if (pick_vld) begin
                    if (!mounted[pick_idx]) begin
                        err_q[pick_idx] <= 1'b1;
                    end else begin
                        g_q                <= pick_idx;
                        tmo_q              <= '0;
                        st_q               <= REQ;
                        sd_lba_q[pick_idx] <= lba_q[pick_idx];
                        rr_ptr_q           <= (pick_idx == IW'(NUM_DEV - 1)) ? '0 : pick_idx + IW'(1);
                        // Write first; a read still pending gets its own later grant.
                        if (pend_wr_q[pick_idx]) begin
                            sd_wr_q[pick_idx] <= 1'b1;
                            op_q              <= OP_WR;
                        end else begin
                            sd_rd_q[pick_idx] <= 1'b1;
                            op_q              <= OP_RD;
                        end
                    end
                end
                REQ: begin
                    if (ack_rise) begin
                        sd_rd_q <= '0;
                        sd_wr_q <= '0;
                        st_q    <= XFER;
                    end else if (tmo_hit) begin
                        sd_rd_q    <= '0;
                        sd_wr_q    <= '0;
                        err_q[g_q] <= 1'b1;
                        st_q       <= IDLE;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                XFER: if (ack_fall) begin
                    done_q[g_q] <= 1'b1;
                    st_q        <= IDLE;
                end
                default: st_q <= IDLE;
            endcase
            // Cold/warm reset: everything but the round-robin pointer; any in-flight ack is orphaned.
            if (soft_reset) begin
                st_q       <= IDLE;
                op_q       <= OP_RD;
                g_q        <= '0;
                tmo_q      <= '0;
                pend_rd_q  <= '0;
                pend_wr_q  <= '0;
                lba_q      <= '0;
                ack_q      <= '0;
                sd_lba_q   <= '0;
                sd_rd_q    <= '0;
                sd_wr_q    <= '0;
                done_q     <= '0;
                err_q      <= '0;
                cpu_wait_q <= 1'b0;
            end
        end
    end

    assign sd_rd    = sd_rd_q;
    assign sd_wr    = sd_wr_q;
    assign sd_lba   = sd_lba_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cpu_wait = cpu_wait_q;

endmodule

// File: tb/tb_sd_req_arbiter.sv
module tb_sd_req_arbiter;

    localparam int N  = 3;
    localparam int LW = 32;

    typedef struct {
        int          dev;
        bit          wr;
        logic [31:0] lba;
        bit          mnt;
        int          ack_len;
        logic [2:0]  exp_rd;
        logic [2:0]  exp_wr;
        logic [2:0]  exp_err;
    } vec_t;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    logic soft_reset = 1'b0;

    logic [N-1:0]         req_rd = '0, req_wr = '0, mounted = '1;
    logic [N-1:0]         ack_man = '0, ack_rsp = '0, sd_ack_a;
    logic [N-1:0][LW-1:0] req_lba = '0;
    logic [N-1:0]         sd_rd_a, sd_wr_a, busy_a, done_a, err_a;
    logic [N-1:0][LW-1:0] sd_lba_a;
    logic                 cpu_wait_a;

    logic [N-1:0]         req_rd_b = '0, req_wr_b = '0, ack_rsp_b = '0;
    logic [N-1:0]         sd_rd_b, sd_wr_b, busy_b, done_b, err_b;
    logic [N-1:0][LW-1:0] sd_lba_b;
    logic                 cpu_wait_b;

    bit   auto_a = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   log_a[$];
    int   log_b[$];
    vec_t vecs[4];

    assign sd_ack_a = ack_man | ack_rsp;

    always #5 clk_sys = ~clk_sys;

    sd_req_arbiter #(.NUM_DEV(N), .LBA_W(LW), .TMO_W(4), .RR(1)) dut_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .soft_reset(soft_reset),
        .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba), .mounted(mounted),
        .sd_ack(sd_ack_a), .sd_rd(sd_rd_a), .sd_wr(sd_wr_a), .sd_lba(sd_lba_a),
        .cpu_wait(cpu_wait_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    sd_req_arbiter #(.NUM_DEV(N), .LBA_W(LW), .TMO_W(4), .RR(0)) dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .soft_reset(soft_reset),
        .req_rd(req_rd_b), .req_wr(req_wr_b), .req_lba(req_lba), .mounted(mounted),
        .sd_ack(ack_rsp_b), .sd_rd(sd_rd_b), .sd_wr(sd_wr_b), .sd_lba(sd_lba_b),
        .cpu_wait(cpu_wait_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Ack the currently requested transfer on device d for len cycles, then expect done.
    task automatic ack_xfer(input int d, input int len, input string nm);
        logic [N-1:0] one;
        one = 3'b001 << d;
        ack_man[d] = 1'b1;
        repeat (len) step();
        ack_man[d] = 1'b0;
        chk({nm, "_no_early_done"}, done_a, 0);
        step();
        chk({nm, "_done"}, done_a, one);
    endtask

    // Grant-order monitors: log each new grant.
    initial begin
        logic [N-1:0] pa, pb;
        pa = '0;
        pb = '0;
        forever begin
            @(negedge clk_sys);
            if ((sd_rd_a | sd_wr_a) != '0 && pa == '0) log_a.push_back(oh_idx(sd_rd_a | sd_wr_a));
            if ((sd_rd_b | sd_wr_b) != '0 && pb == '0) log_b.push_back(oh_idx(sd_rd_b | sd_wr_b));
            pa = sd_rd_a | sd_wr_a;
            pb = sd_rd_b | sd_wr_b;
        end
    end

    // Automatic hps_io stand-ins: ack 4 cycles once a request shows up.
    initial begin
        forever begin
            @(posedge clk_sys);
            #2;
            if (auto_a && ((sd_rd_a | sd_wr_a) != '0)) begin
                int k;
                k = oh_idx(sd_rd_a | sd_wr_a);
                ack_rsp[k] = 1'b1;
                repeat (4) @(posedge clk_sys);
                #2 ack_rsp[k] = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_sys);
            #2;
            if ((sd_rd_b | sd_wr_b) != '0) begin
                int k;
                k = oh_idx(sd_rd_b | sd_wr_b);
                ack_rsp_b[k] = 1'b1;
                repeat (4) @(posedge clk_sys);
                #2 ack_rsp_b[k] = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rr[3];
        int exp_fp[3];
        int cyc;
        exp_rr = '{1, 2, 0};
        exp_fp = '{0, 1, 2};

        //            dev wr  lba           mnt len  rd      wr      err
        vecs[0] = '{2, 0, 32'h0000_0777, 0, 0,   3'b000, 3'b000, 3'b100};
        vecs[1] = '{1, 1, 32'h0000_ABCD, 1, 3,   3'b000, 3'b010, 3'b000};
        vecs[2] = '{2, 0, 32'hFFFF_FFFF, 1, 5,   3'b100, 3'b000, 3'b000};
        vecs[3] = '{0, 0, 32'h0000_0123, 1, 512, 3'b001, 3'b000, 3'b000};

        // Reset state
        repeat (2) step();
        chk("rst_sd_rd", sd_rd_a, 0);
        chk("rst_sd_wr", sd_wr_a, 0);
        chk("rst_sd_lba", sd_lba_a, 0);
        chk("rst_cpu_wait", cpu_wait_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done_err", {done_a, err_a}, 0);
        reset_n = 1'b1;
        step();

        // Single-transaction table
        for (int r = 0; r < 4; r++) begin
            vec_t v;
            string p;
            v = vecs[r];
            p = $sformatf("row%0d", r);
            step();
            mounted[v.dev] = v.mnt;
            req_lba[v.dev] = v.lba;
            if (v.wr) req_wr[v.dev] = 1'b1;
            else      req_rd[v.dev] = 1'b1;
            step();
            req_rd = '0;
            req_wr = '0;
            step();
            chk({p, "_sd_rd"}, sd_rd_a, v.exp_rd);
            chk({p, "_sd_wr"}, sd_wr_a, v.exp_wr);
            chk({p, "_err"}, err_a, v.exp_err);
            chk({p, "_busy"}, busy_a, v.exp_rd | v.exp_wr);
            chk({p, "_cpu_wait_hi"}, cpu_wait_a, 1);
            if (v.exp_err != 0) begin
                step();
                chk({p, "_cpu_wait_lo"}, cpu_wait_a, 0);
                chk({p, "_err_pulse"}, err_a, 0);
                chk({p, "_no_req"}, sd_rd_a | sd_wr_a, 0);
            end else begin
                chk({p, "_sd_lba"}, sd_lba_a[v.dev], v.lba);
                ack_man[v.dev] = 1'b1;
                step();
                chk({p, "_req_drop"}, sd_rd_a | sd_wr_a, 0);
                repeat (v.ack_len - 1) step();
                ack_man[v.dev] = 1'b0;
                chk({p, "_no_early_done"}, done_a, 0);
                step();
                chk({p, "_done"}, done_a, v.exp_rd | v.exp_wr);
                chk({p, "_cpu_wait_f1"}, cpu_wait_a, 1);
                step();
                chk({p, "_cpu_wait_f2"}, cpu_wait_a, 0);
                chk({p, "_done_pulse"}, done_a, 0);
            end
        end

        // Grant order: round-robin from pointer 1 versus fixed priority
        log_a.delete();
        log_b.delete();
        auto_a = 1'b1;
        step();
        req_rd = '1;
        req_rd_b = '1;
        step();
        req_rd = '0;
        req_rd_b = '0;
        cyc = 0;
        while ((cpu_wait_a || cpu_wait_b || cyc < 4) && cyc < 400) begin
            step();
            cyc++;
        end
        chk("order_settle", (cyc < 400) ? 1 : 0, 1);
        auto_a = 1'b0;
        repeat (8) step();
        chk("order_rr_count", log_a.size(), 3);
        chk("order_fp_count", log_b.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < log_a.size()) chk($sformatf("order_rr_%0d", i), log_a[i], exp_rr[i]);
            if (i < log_b.size()) chk($sformatf("order_fp_%0d", i), log_b[i], exp_fp[i]);
        end

        // Read and write together on dev1: write first, then read
        step();
        req_rd[1] = 1'b1;
        req_wr[1] = 1'b1;
        step();
        req_rd = '0;
        req_wr = '0;
        step();
        chk("rw_first_wr", sd_wr_a, 3'b010);
        chk("rw_first_rd", sd_rd_a, 0);
        ack_xfer(1, 3, "rw_wr");
        chk("rw_busy_between", busy_a, 3'b010);
        step();
        chk("rw_second_rd", sd_rd_a, 3'b010);
        chk("rw_second_wr", sd_wr_a, 0);
        ack_xfer(1, 3, "rw_rd");
        step();
        chk("rw_idle_wait", cpu_wait_a, 0);

        // Ack timeout with TMO_W=4
        step();
        req_rd[0] = 1'b1;
        step();
        req_rd = '0;
        step();
        chk("tmo_grant", sd_rd_a, 3'b001);
        repeat (14) step();
        chk("tmo_hold", sd_rd_a, 3'b001);
        chk("tmo_no_early_err", err_a, 0);
        step();
        chk("tmo_drop", sd_rd_a, 0);
        chk("tmo_err", err_a, 3'b001);
        step();
        chk("tmo_err_pulse", err_a, 0);
        chk("tmo_cpu_wait", cpu_wait_a, 0);
        chk("tmo_busy", busy_a, 0);

        // Soft reset during XFER; the late ack fall must be ignored
        step();
        req_lba[2] = 32'h0000_55AA;
        req_rd[2] = 1'b1;
        step();
        req_rd = '0;
        step();
        chk("sr_grant", sd_rd_a, 3'b100);
        chk("sr_lba", sd_lba_a[2], 32'h0000_55AA);
        ack_man[2] = 1'b1;
        step();
        chk("sr_in_xfer", sd_rd_a, 0);
        chk("sr_busy_xfer", busy_a, 3'b100);
        step();
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        chk("sr_cleared_req", sd_rd_a | sd_wr_a, 0);
        chk("sr_cleared_wait", cpu_wait_a, 0);
        chk("sr_cleared_busy", busy_a, 0);
        chk("sr_cleared_lba", sd_lba_a[2], 0);
        step();
        ack_man[2] = 1'b0;
        step();
        chk("sr_no_done1", done_a, 0);
        step();
        chk("sr_no_done2", done_a, 0);
        chk("sr_idle_wait", cpu_wait_a, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
